// File: rtl/fsm_stream_pkg.sv
// Shared types and constants for the fsm_stream_sched block.
//   state_t          : scheduler FSM states (IDLE, CLEAR, SHIFT, RESP)
//   ENC_S0 / ENC_S1  : the two states of the serial Mealy encoder
//   NREQ_DEF, DW_DEF : default requester count and word width
package fsm_stream_pkg;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 8;

  localparam logic ENC_S0 = 1'b0;
  localparam logic ENC_S1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/fsm_bit_enc.sv
// Two-state serial Mealy encoder: dout = state ^ din, next state = state ^ din.
// Over a frame, output bit i is the XOR of input bits 0..i.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-low reset (state -> ENC_S0)
//   clr   : force state to ENC_S0; wins over en
//   en    : advance the encoder by one input bit
//   din   : serial input bit
//   dout  : combinational output for the current state and din
module fsm_bit_enc
  import fsm_stream_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic state;

  assign dout = state ^ din;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ENC_S0;
    end else if (clr) begin
      state <= ENC_S0;
    end else if (en && din) begin
      state <= (state == ENC_S0) ? ENC_S1 : ENC_S0;
    end
  end

endmodule

// File: rtl/fsm_stream_sched.sv
// Round-robin scheduler sharing one serial encoder among NREQ requesters.
// A granted word is shifted LSB-first through fsm_bit_enc and the encoder
// outputs are collected into rsp_data, then held until rsp_ready.
//
// Optional build macro FSM_STREAM_SCHED_PRIO_EN: requester 0 becomes
// strict priority and never moves the round-robin pointer; requesters
// 1..NREQ-1 rotate among themselves. Without it, all requesters rotate.
//
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-low reset
//   req_valid : per-requester request
//   req_data  : requester i word at [i*DW +: DW]
//   req_ready : one-hot grant, combinational, only in IDLE
//   rsp_valid : response available (held until rsp_ready)
//   rsp_id    : index of the served requester
//   rsp_data  : encoded word
//   rsp_ready : consumer accepts response
//   busy      : high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | arbitrate; grant, capture word, move to CLEAR
// CLEAR | zero encoder and bit counter
// SHIFT | one bit per cycle through the encoder, DW cycles
// RESP  | present response until rsp_ready
module fsm_stream_sched
  import fsm_stream_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [DW-1:0]             rsp_data,
  input  logic                      rsp_ready,
  output logic                      busy
);

  localparam int IW = $clog2(NREQ);
  localparam int SW = IW + 1;
  localparam int CW = $clog2(DW);

  state_t          state;
  logic [IW-1:0]   last;
  logic [DW-1:0]   cap;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] cand;
  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [SW-1:0]   sum;
  logic [IW-1:0]   pos;
  logic [DW-1:0]   gnt_word;

  logic            enc_clr;
  logic            enc_en;
  logic            enc_din;
  logic            enc_dout;

  // Rotating search starting just after the last granted requester.
  // sum is one bit wider than the index so last+k cannot overflow before
  // the modulo-NREQ fold.
  always_comb begin
    cand      = req_valid;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    pos       = '0;
`ifdef FSM_STREAM_SCHED_PRIO_EN
    cand[0]   = 1'b0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, last} + SW'(k);
      if (sum >= SW'(NREQ)) begin
        sum = sum - SW'(NREQ);
      end
      pos = sum[IW-1:0];
      if (!gnt_found && cand[pos]) begin
        gnt_found = 1'b1;
        gnt_idx   = pos;
      end
    end
`ifdef FSM_STREAM_SCHED_PRIO_EN
    if (req_valid[0]) begin
      gnt_found = 1'b1;
      gnt_idx   = '0;
    end
`endif
  end

  assign gnt_word  = req_data[int'(gnt_idx)*DW +: DW];

  // Gated by reset so nothing looks accepted while reset is held.
  assign req_ready = (reset && (state == IDLE) && gnt_found) ?
                     (NREQ'(1) << gnt_idx) : '0;

  assign busy      = (state != IDLE);

  assign enc_clr   = (state == CLEAR);
  assign enc_en    = (state == SHIFT);
  assign enc_din   = cap[cnt];

  fsm_bit_enc u_enc (
    .clk   (clk),
    .reset (reset),
    .clr   (enc_clr),
    .en    (enc_en),
    .din   (enc_din),
    .dout  (enc_dout)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= IW'(NREQ - 1);
      cap       <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            cap    <= gnt_word;
            rsp_id <= gnt_idx;
`ifdef FSM_STREAM_SCHED_PRIO_EN
            if (gnt_idx != '0) begin
              last <= gnt_idx;
            end
`else
            last   <= gnt_idx;
`endif
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          rsp_data[cnt] <= enc_dout;
          cnt           <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_stream_sched.sv
// Scoreboard bench for fsm_stream_sched. A negedge monitor predicts each
// grant from a round-robin reference, queues the expected response and
// checks outputs every cycle; the main process only drives stimulus.
module tb_fsm_stream_sched;
  import fsm_stream_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IW   = $clog2(NREQ);
  localparam int INF  = 32'h7fffffff;

  localparam int M_HOLD = 0;
  localparam int M_ONE  = 1;
  localparam int M_RAND = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic [IW-1:0]      rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               rsp_ready = 1'b0;
  logic               busy;

  fsm_stream_sched #(.NREQ(NREQ), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            gcyc;
  } exp_t;

  exp_t            sb[$];
  int              total = 0;
  int              bad = 0;
  int              free_at = 0;
  int              m_last = NREQ - 1;
  int              n_grants = 0;
  bit              rst_prev = 1'b0;
  logic [NREQ-1:0] hs_vec = '0;
  int              mode = M_HOLD;

  // Output bit i is the parity of input bits 0..i.
  function automatic logic [DW-1:0] enc_model(input logic [DW-1:0] d);
    logic [DW-1:0] ones;
    logic [DW-1:0] r;
    ones = '1;
    r    = '0;
    for (int i = 0; i < DW; i++) r[i] = ^(d & (ones >> (DW - 1 - i)));
    return r;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
`ifdef FSM_STREAM_SCHED_PRIO_EN
    if (v[0]) return 0;
    v[0] = 1'b0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    int            g;
    logic [31:0]   exp_rdy;
    bit            exp_rv;
    if (!reset) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      if (rst_prev) begin
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      sb.delete();
      free_at  = cyc + 1;
      m_last   = NREQ - 1;
      hs_vec   = '0;
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      chk("busy", 32'(busy), 32'(cyc < free_at));
      g       = (cyc >= free_at) ? pick(req_valid, m_last) : -1;
      exp_rdy = (g < 0) ? 32'd0 : (32'd1 << g);
      chk("req_ready", 32'(req_ready), exp_rdy);
      hs_vec = req_ready & req_valid;
      if (g >= 0) begin
        sb.push_back('{id: g, data: enc_model(req_data[g*DW +: DW]), gcyc: cyc});
`ifdef FSM_STREAM_SCHED_PRIO_EN
        if (g != 0) m_last = g;
`else
        m_last = g;
`endif
        free_at = INF;
        n_grants++;
      end
      exp_rv = (sb.size() > 0) && (cyc >= sb[0].gcyc + DW + 2);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv && rsp_valid) begin
        chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
        chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
        if (rsp_ready) begin
          void'(sb.pop_front());
          free_at = cyc + 1;
        end
      end
    end
  end

  task automatic cycle();
    logic [NREQ-1:0] hs;
    @(posedge clk);
    hs = hs_vec;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) begin
        case (mode)
          M_HOLD: req_data[i*DW +: DW] = DW'($urandom);
          M_RAND: begin
            req_valid[i]          = 1'($urandom_range(0, 1));
            req_data[i*DW +: DW]  = DW'($urandom);
          end
          default: req_valid[i] = 1'b0;
        endcase
      end else if (mode == M_RAND) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i]         = 1'b1;
          req_data[i*DW +: DW] = DW'($urandom);
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    if (mode == M_RAND) rsp_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic wait_grants(input int n, input int budget);
    int target;
    int b;
    target = n_grants + n;
    b = 0;
    while (n_grants < target && b < budget) begin
      cycle();
      b++;
    end
    if (n_grants < target) timeout("wait_grants");
  endtask

  task automatic drain(input int budget);
    int b;
    b = 0;
    while (!(req_valid == '0 && sb.size() == 0 && cyc >= free_at) && b < budget) begin
      cycle();
      b++;
    end
    if (!(req_valid == '0 && sb.size() == 0)) timeout("drain");
  endtask

  task automatic send(input int id, input logic [DW-1:0] d);
    req_data[id*DW +: DW] = d;
    req_valid[id]         = 1'b1;
    drain(60);
  endtask

  initial begin
    logic [DW-1:0] kat[4];
    int b;
    kat = '{8'h01, 8'hFF, 8'h03, 8'h00};
    reset     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'($urandom);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // All requesters valid: rotation 0,1,2,3,0 every DW+3 cycles
    mode = M_HOLD;
    wait_grants(5, 120);
    mode = M_ONE;
    drain(200);

    // Known-answer words through one requester
    for (int i = 0; i < 4; i++) send(2, kat[i]);

    // Backpressure while other requests are pending
    rsp_ready = 1'b0;
    req_valid = 4'b1001;
    b = 0;
    while (!rsp_valid && b < 40) begin
      cycle();
      b++;
    end
    if (!rsp_valid) timeout("wait_rsp");
    repeat (20) cycle();
    rsp_ready = 1'b1;
    drain(100);

    // Reset during SHIFT bit 4, then the encoder must start clean
    req_data[1*DW +: DW] = 8'hFF;
    req_valid[1]         = 1'b1;
    wait_grants(1, 20);
    repeat (5) cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    repeat (3) cycle();
    send(1, 8'hFF);

    // Randomized traffic and backpressure
    mode = M_RAND;
    repeat (800) cycle();
    mode = M_ONE;
    rsp_ready = 1'b1;
    drain(300);

`ifdef FSM_STREAM_SCHED_PRIO_EN
    mode = M_HOLD;
    req_valid = 4'b0111;
    wait_grants(4, 100);
    req_valid[0] = 1'b0;
    wait_grants(4, 100);
    mode = M_ONE;
    drain(100);
`endif

    repeat (3) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
